// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction field layout, opcode constants and
// the fetch-stage state encoding.
package proc_pkg;

    localparam int unsigned InstrW   = 16;
    localparam int unsigned OpcodeW  = 5;
    localparam int unsigned FunctW   = 4;
    localparam int unsigned RegIdxW  = 3;

    localparam int unsigned OpcodeLsb = 11;
    localparam int unsigned RsLsb     = 8;
    localparam int unsigned RtLsb     = 5;
    localparam int unsigned FunctLsb  = 1;

    localparam logic [OpcodeW-1:0] OpHalt = 5'b11111;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StValid,
        StFlush,
        StHalt
    } fetch_state_e;

    function automatic logic [OpcodeW-1:0] get_opcode(input logic [InstrW-1:0] ins);
        return ins[OpcodeLsb +: OpcodeW];
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Fetch program counter: synchronous load or wrap-around increment, async reset
// to the reset vector.
module fetch_pc #(
    parameter int unsigned         ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives instruction memory over req/ack, registers the
// returned word and presents it with decoded fields until the consumer takes it.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RST_N,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_ack,
    input  logic                stall,
    input  logic                branch_valid,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [OpcodeW-1:0]  opcode,
    output logic [RegIdxW-1:0]  rs,
    output logic [RegIdxW-1:0]  rt,
    output logic [FunctW-1:0]   funct,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted
);

    fetch_state_e       state_d, state_q;
    logic [ADDR_W-1:0]  tgt_d, tgt_q;
    logic [ADDR_W-1:0]  pc_d, pc_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               req_d, req_q;
    logic               valid_d, valid_q;
    logic               halted_d, halted_q;

    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_load_val;
    logic [ADDR_W-1:0] fetch_addr;
    logic              capture;
    logic              drop_req;
    logic              ack_eff;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .load_i   (pc_load),
        .target_i (pc_load_val),
        .inc_i    (pc_inc),
        .pc_o     (fetch_addr)
    );

    // An ack only counts while a request is actually on the bus.
    assign ack_eff = imem_ack && req_q;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load_val = branch_target;
        capture     = 1'b0;
        drop_req    = 1'b0;

        case (state_q)
            StIdle: begin
                pc_load = branch_valid;
                state_d = StReq;
            end
            StReq: begin
                if (branch_valid) begin
                    if (ack_eff) begin
                        // Returned word is stale; idle the bus one cycle before the new address.
                        pc_load  = 1'b1;
                        drop_req = 1'b1;
                    end else if (req_q) begin
                        tgt_d   = branch_target;
                        state_d = StFlush;
                    end else begin
                        pc_load = 1'b1;
                    end
                end else if (ack_eff) begin
                    capture = 1'b1;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (branch_valid) begin
                    pc_load = 1'b1;
                    state_d = StReq;
                end else if (!stall) begin
                    if (get_opcode(instr_q) == OpHalt) begin
                        state_d = StHalt;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StFlush: begin
                if (ack_eff) begin
                    pc_load     = 1'b1;
                    pc_load_val = branch_valid ? branch_target : tgt_q;
                    state_d     = StReq;
                end else if (branch_valid) begin
                    tgt_d = branch_target;
                end
            end
            StHalt: begin
                if (branch_valid) begin
                    pc_load = 1'b1;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_d    = ((state_d == StReq) || (state_d == StFlush)) && !drop_req;
        valid_d  = (state_d == StValid);
        halted_d = (state_d == StHalt);
        instr_d  = capture ? imem_rdata : instr_q;
        pc_d     = capture ? fetch_addr : pc_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            tgt_q    <= RESET_PC;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_addr;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign opcode      = instr_q[OpcodeLsb +: OpcodeW];
    assign rs          = instr_q[RsLsb +: RegIdxW];
    assign rt          = instr_q[RtLsb +: RegIdxW];
    assign funct       = instr_q[FunctLsb +: FunctW];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the processor. It sits directly upstream of the control unit and the register file. It holds the program counter and issues word reads to instruction memory over a req/ack handshake, then registers the returned instruction. It presents the instruction and its decoded fields (5-bit opcode, register indices, 4-bit function code) with a valid flag, holds them while the consumer stalls, and redirects on branch.

## Interface
- ADDR_W, 8, instruction memory word-address width; PC width.
- INSTR_W, 16, instruction width; fixed at 16 by the field layout below.
- RESET_PC, 0, PC value after reset.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  ADDR_W  read word address; stable while imem_req high.
- imem_rdata  in  INSTR_W  read data; valid in the cycle imem_ack is high.
- imem_ack  in  1  read complete; may coincide with the first imem_req cycle.
- stall  in  1  consumer not ready; holds the presented instruction.
- branch_valid  in  1  redirect request; one-cycle pulse.
- branch_target  in  ADDR_W  redirect word address.
- instr_valid  out  1  instr and its fields are valid.
- instr  out  INSTR_W  raw instruction.
- opcode  out  5  instr[15:11].
- rs  out  3  instr[10:8].
- rt  out  3  instr[7:5].
- funct  out  4  instr[4:1]; instr[0] is reserved and ignored.
- pc  out  ADDR_W  address of the presented instruction.
- halted  out  1  fetch stopped on HALT opcode 5'b11111.

## Operation
- States: IDLE, REQ, VALID, FLUSH, HALT.
- Reset (asynchronous):
  - All outputs go to 0, except imem_addr = RESET_PC and pc = RESET_PC.
  - State goes to IDLE, fetch PC to RESET_PC.
  - An outstanding memory request is abandoned.
- IDLE -> REQ unconditionally, one cycle after reset release.
- REQ: imem_req = 1, imem_addr = fetch PC.
  - On ack: register imem_rdata into instr, set pc = fetch PC, go to VALID.
- VALID: instr_valid = 1.
  - If stall = 1, hold all outputs.
  - If stall = 0 and opcode != HALT: the instruction is consumed at this edge. Fetch PC becomes PC + 1, wrapping modulo 2^ADDR_W. Go to REQ.
  - If stall = 0 and opcode == HALT: go to HALT.
- HALT: halted = 1, instr_valid = 0, no requests. Leave only on branch or reset.
- Branch has priority over stall and ack:
  - In IDLE, VALID or HALT: fetch PC becomes branch_target, instr_valid drops, halted drops, go to REQ.
  - In REQ with imem_ack in the same cycle: discard the data, fetch PC becomes branch_target, stay in REQ. imem_req drops for one cycle so that a new address is issued.
  - In REQ without ack: latch the target, go to FLUSH. imem_req stays high at the old address until ack.
  - In FLUSH: on ack, discard the data and go to REQ at the latched target. A further branch in FLUSH overwrites the latched target.
- Instruction fields are combinational slices of the instr register.

## Timing
- Zero-wait memory (ack in the first REQ cycle): instr_valid rises 1 cycle after req rises.
- Steady-state throughput with no stall: one instruction per 2 cycles (REQ, VALID).
- Branch to first valid instruction at the target: 2 cycles with zero-wait memory, measured from the branch edge.
- imem_addr changes only while imem_req is low, or on the edge at which ack is sampled.
- Outputs are glitch-free registers, except the field slices of instr.

## Structure
- Shared package proc_pkg holds:
  - opcode width (5) and funct width (4);
  - field bit positions;
  - the HALT opcode constant;
  - the fetch state enumeration.
- The control unit uses the same opcode constants from proc_pkg.
- One sub-module is natural: fetch_pc. It is the PC register with synchronous load and increment-with-wrap, and is reset asynchronously to RESET_PC.

## Test plan
- Reset release, zero-wait memory returning 16'h1000, then 16'h5804, no stall:
  - imem_addr sequence 0, 1;
  - instr_valid high at cycles 2 and 4;
  - opcode values 5'b00010, then 5'b01011.
- stall held 3 cycles during VALID: instr, pc and instr_valid are unchanged; no imem_req until the cycle after stall falls.
- branch_valid with target 8'h40 while REQ is waiting (ack delayed 3 cycles): the old data is discarded, next imem_addr = 8'h40, and no instr_valid for the discarded word.
- Branch coincident with ack, and branch during stall: in both cases the data or held instruction is dropped and the next fetch is at the target.
- Fetch of 16'hF800 at PC 8'hFF: halted = 1 and requests stop. A later branch to 8'h00 resumes fetching.
- RST_N asserted mid-REQ: outputs clear immediately; after release the first imem_addr = RESET_PC.
